clkswitch_speed_ctrl: RTL



---
 rtl/clkswitch_speed_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/clkswitch_speed_ctrl.sv
// Speed controller ahead of the two-clock glitch-free switch: decodes each 65816
// bus cycle and requests the high-speed clock when the access allows it.
module clkswitch_speed_ctrl #(
  parameter logic [23:0] CFG_ADDR    = 24'h00FEFF,
  parameter int          HOLD_CYCLES = 4,
  parameter int          TIMEOUT     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vda,
  input  logic        vpa,
  input  logic        rnw,
  input  logic [23:0] addr,
  input  logic [7:0]  din,
  input  logic        loselect,
  input  logic        hiselect,
  output logic        hienable,
  output logic [2:0]  cfg_q,
  output logic        slow_cyc,
  output logic        handover_err
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {SLOW, TO_SLOW, FAST, TO_FAST} state_t;

  state_t          state, state_n;
  logic [HW-1:0]   hold, hold_n;
  logic [WW-1:0]   wdog, wdog_n;
  logic            hien_n;
  logic [2:0]      cfg_n;
  logic            err_n;
  logic            lo_m, lo_s, hi_m, hi_s;

  logic            turbo_en, ram_fast, rom_fast;
  logic            acc, bank0, io_page, slow_acc, cfg_wr, wd_expire;
  logic            unused_din;

  assign {rom_fast, ram_fast, turbo_en} = cfg_q;
  assign unused_din = ^din[7:3];

  // Host I/O pages FC..FE and unshadowed bank-0 memory must run on the host clock.
  assign acc      = vda | vpa;
  assign bank0    = (addr[23:16] == 8'h00);
  assign io_page  = (addr[15:8] >= 8'hFC) && (addr[15:8] <= 8'hFE);
  assign slow_acc = acc & (!turbo_en | (bank0 & (io_page
                                                | (!addr[15] & !ram_fast)
                                                | (addr[15] & !io_page & !rom_fast))));
  assign cfg_wr   = vda & !rnw & (addr == CFG_ADDR);

  assign wd_expire = ((state == TO_SLOW) || (state == TO_FAST)) && (wdog == WD_LAST);
  assign slow_cyc  = (state == SLOW) || (state == TO_SLOW);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SLOW;
      hold         <= '0;
      wdog         <= '0;
      hienable     <= 1'b0;
      cfg_q        <= 3'b000;
      handover_err <= 1'b0;
      lo_m         <= 1'b0;
      lo_s         <= 1'b0;
      hi_m         <= 1'b0;
      hi_s         <= 1'b0;
    end else begin
      state        <= state_n;
      hold         <= hold_n;
      wdog         <= wdog_n;
      hienable     <= hien_n;
      cfg_q        <= cfg_n;
      handover_err <= err_n;
      lo_m         <= loselect;
      lo_s         <= lo_m;
      hi_m         <= hiselect;
      hi_s         <= hi_m;
    end
  end

  // The watchdog outranks both completion and abort, so a stuck switch always lands in SLOW.
  always_comb begin
    state_n = state;
    hold_n  = hold;
    wdog_n  = '0;
    hien_n  = hienable;
    cfg_n   = cfg_q;
    err_n   = handover_err;
    if (cfg_wr) cfg_n = din[2:0];
    case (state)
      FAST: begin
        if (slow_acc) begin
          state_n = TO_SLOW;
          hien_n  = 1'b0;
        end
      end
      TO_SLOW: begin
        if (wd_expire) begin
          state_n  = SLOW;
          hien_n   = 1'b0;
          cfg_n[0] = 1'b0;
          err_n    = 1'b1;
        end else if (lo_s && !hi_s) begin
          state_n = SLOW;
          hold_n  = HOLD_INIT;
        end else begin
          wdog_n = wdog + WW'(1);
        end
      end
      SLOW: begin
        if (slow_acc) begin
          hold_n = HOLD_INIT;
        end else if (hold != '0) begin
          hold_n = hold - HW'(1);
        end else if (turbo_en) begin
          state_n = TO_FAST;
          hien_n  = 1'b1;
        end
      end
      TO_FAST: begin
        if (wd_expire) begin
          state_n  = SLOW;
          hien_n   = 1'b0;
          cfg_n[0] = 1'b0;
          err_n    = 1'b1;
        end else if (slow_acc) begin
          state_n = TO_SLOW;
          hien_n  = 1'b0;
        end else if (hi_s && !lo_s) begin
          state_n = FAST;
        end else begin
          wdog_n = wdog + WW'(1);
        end
      end
      default: begin
        state_n = SLOW;
        hien_n  = 1'b0;
      end
    endcase
  end

endmodule
